bram_port_arbiter: RTL and testbench

- Shares one simple-dual-port block RAM (2048 x 8, write port A, read port B, one common clock) between two writers and two readers.
- Writers use round-robin arbitration on port A. Readers use fixed priority on port B: reader 0 is the display scan-out and reader 1 is the auxiliary/debug reader. A starvation limit protects reader 1.
- Sits between the requesters and the SDPR instance, drives all SDPR enables and addresses, and returns tagged read data.

---
 rtl/bram_pkg.sv | 18 +
 rtl/rr_arb2.sv | 39 +++
 rtl/bram_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants and types for the block RAM port arbiter
package bram_pkg;

  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 8;
  localparam int BRAM_DEPTH  = 2048;

  // Reader identities carried through the read-return tag pipeline
  localparam logic RD_DISP = 1'b0;  // display scan-out
  localparam logic RD_AUX  = 1'b1;  // auxiliary / debug reader

  // One tag per issued read: valid flag plus the reader that owns the data
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter with pointer update
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Pointer names the requester that wins the next contended cycle
  logic rr_q;
  logic rr_d;

  // Lone requester always wins; on contention the pointer decides and flips
  always_comb begin
    gnt  = 2'b00;
    rr_d = rr_q;
    if (!rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt  = rr_q ? 2'b10 : 2'b01;
          rr_d = ~rr_q;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer register, starts by favouring requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one simple-dual-port BRAM between two writers and two readers
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W     = BRAM_ADDR_W,
  parameter int DATA_W     = BRAM_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req0,
  input  logic              wr_req1,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [DATA_W-1:0] wr_data1,
  output logic              wr_gnt0,
  output logic              wr_gnt1,
  input  logic              rd_req0,
  input  logic              rd_req1,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic              rd_gnt0,
  output logic              rd_gnt1,
  output logic              rd_vld0,
  output logic              rd_vld1,
  output logic [DATA_W-1:0] rd_data,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [DATA_W-1:0] bram_dina,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb
);

  localparam int SC_W = $clog2(STARVE_LIM + 1);

  // Write-side arbitration results
  logic [1:0]        wr_gnt;
  logic              wr_any;
  logic [ADDR_W-1:0] wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;

  // Read-side arbitration
  logic              rd_cand0;
  logic              rd_cand1;
  logic              rd_g0;
  logic              rd_g1;
  logic              starve_hit;
  logic [SC_W-1:0]   starve_q;
  logic [SC_W-1:0]   starve_d;

  // Port A issue registers
  logic              ena_q;
  logic              ena_d;
  logic [ADDR_W-1:0] addra_q;
  logic [ADDR_W-1:0] addra_d;
  logic [DATA_W-1:0] dina_q;
  logic [DATA_W-1:0] dina_d;

  // Port B issue registers
  logic              enb_q;
  logic              enb_d;
  logic [ADDR_W-1:0] addrb_q;
  logic [ADDR_W-1:0] addrb_d;

  // Read-return tag pipeline and output registers
  rd_tag_t [RD_LAT:0] tag_q;
  rd_tag_t [RD_LAT:0] tag_d;
  logic              vld0_q;
  logic              vld0_d;
  logic              vld1_q;
  logic              vld1_d;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req ({wr_req1, wr_req0}),
    .gnt (wr_gnt)
  );

  // Select the address/data of whichever writer won this cycle
  always_comb begin
    wr_any      = |wr_gnt;
    wr_addr_sel = wr_gnt[1] ? wr_addr1 : wr_addr0;
    wr_data_sel = wr_gnt[1] ? wr_data1 : wr_data0;
  end

  // Fixed-priority read arbitration with collision masking and aux-reader starvation override
  always_comb begin
    // A read hitting the address being written this cycle is held off one cycle
    rd_cand0   = !rst && rd_req0 && !(wr_any && (rd_addr0 == wr_addr_sel));
    rd_cand1   = !rst && rd_req1 && !(wr_any && (rd_addr1 == wr_addr_sel));
    starve_hit = (starve_q == SC_W'(STARVE_LIM));
    if (starve_hit) begin
      rd_g1 = rd_cand1;
      rd_g0 = rd_cand0 && !rd_cand1;
    end else begin
      rd_g0 = rd_cand0;
      rd_g1 = rd_cand1 && !rd_cand0;
    end
    // Count denied cycles of a pending aux read, saturating at the limit
    if (!rd_req1 || rd_g1) begin
      starve_d = '0;
    end else if (!starve_hit) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Next-state for the BRAM port registers; addresses and data hold when idle
  always_comb begin
    ena_d   = wr_any;
    addra_d = wr_any ? wr_addr_sel : addra_q;
    dina_d  = wr_any ? wr_data_sel : dina_q;
    enb_d   = rd_g0 || rd_g1;
    if (rd_g1) begin
      addrb_d = rd_addr1;
    end else if (rd_g0) begin
      addrb_d = rd_addr0;
    end else begin
      addrb_d = addrb_q;
    end
  end

  // Tag pipeline shifts one stage per cycle; last stage steers the valid pulses
  always_comb begin
    tag_d[0].vld = rd_g0 || rd_g1;
    tag_d[0].id  = rd_g1 ? RD_AUX : RD_DISP;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    vld0_d    = tag_q[RD_LAT].vld && (tag_q[RD_LAT].id == RD_DISP);
    vld1_d    = tag_q[RD_LAT].vld && (tag_q[RD_LAT].id == RD_AUX);
    rd_data_d = bram_doutb;
  end

  // State registers; reset drops in-flight reads by clearing the tag pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      ena_q     <= 1'b0;
      addra_q   <= '0;
      dina_q    <= '0;
      enb_q     <= 1'b0;
      addrb_q   <= '0;
      tag_q     <= '0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      ena_q     <= ena_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      enb_q     <= enb_d;
      addrb_q   <= addrb_d;
      tag_q     <= tag_d;
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign wr_gnt0    = wr_gnt[0];
  assign wr_gnt1    = wr_gnt[1];
  assign rd_gnt0    = rd_g0;
  assign rd_gnt1    = rd_g1;
  assign bram_ena   = ena_q;
  assign bram_wea   = ena_q;
  assign bram_addra = addra_q;
  assign bram_dina  = dina_q;
  assign bram_enb   = enb_q;
  assign bram_addrb = addrb_q;
  assign rd_vld0    = vld0_q;
  assign rd_vld1    = vld1_q;
  assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst;

  // Instance A: default RD_LAT = 1
  logic        wr_req0, wr_req1;
  logic [10:0] wr_addr0, wr_addr1;
  logic [7:0]  wr_data0, wr_data1;
  logic        wr_gnt0, wr_gnt1;
  logic        rd_req0, rd_req1;
  logic [10:0] rd_addr0, rd_addr1;
  logic        rd_gnt0, rd_gnt1, rd_vld0, rd_vld1;
  logic [7:0]  rd_data;
  logic        bram_ena, bram_wea, bram_enb;
  logic [10:0] bram_addra, bram_addrb;
  logic [7:0]  bram_dina, bram_doutb;
  logic [7:0]  mem_a [0:2047];

  // Instance B: RD_LAT = 2, reads only
  logic        b_wr_req0, b_wr_req1;
  logic [10:0] b_wr_addr0, b_wr_addr1;
  logic [7:0]  b_wr_data0, b_wr_data1;
  logic        b_wr_gnt0, b_wr_gnt1;
  logic        b_rd_req0, b_rd_req1;
  logic [10:0] b_rd_addr0, b_rd_addr1;
  logic        b_rd_gnt0, b_rd_gnt1, b_rd_vld0, b_rd_vld1;
  logic [7:0]  b_rd_data;
  logic        b_bram_ena, b_bram_wea, b_bram_enb;
  logic [10:0] b_bram_addra, b_bram_addrb;
  logic [7:0]  b_bram_dina, b_bram_doutb, b_s1;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .wr_req0(wr_req0), .wr_req1(wr_req1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_gnt0(wr_gnt0), .wr_gnt1(wr_gnt1),
    .rd_req0(rd_req0), .rd_req1(rd_req1), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_gnt0(rd_gnt0), .rd_gnt1(rd_gnt1), .rd_vld0(rd_vld0), .rd_vld1(rd_vld1),
    .rd_data(rd_data), .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra),
    .bram_dina(bram_dina), .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_doutb(bram_doutb)
  );

  bram_port_arbiter #(.RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .wr_req0(b_wr_req0), .wr_req1(b_wr_req1), .wr_addr0(b_wr_addr0), .wr_addr1(b_wr_addr1),
    .wr_data0(b_wr_data0), .wr_data1(b_wr_data1), .wr_gnt0(b_wr_gnt0), .wr_gnt1(b_wr_gnt1),
    .rd_req0(b_rd_req0), .rd_req1(b_rd_req1), .rd_addr0(b_rd_addr0), .rd_addr1(b_rd_addr1),
    .rd_gnt0(b_rd_gnt0), .rd_gnt1(b_rd_gnt1), .rd_vld0(b_rd_vld0), .rd_vld1(b_rd_vld1),
    .rd_data(b_rd_data), .bram_ena(b_bram_ena), .bram_wea(b_bram_wea), .bram_addra(b_bram_addra),
    .bram_dina(b_bram_dina), .bram_enb(b_bram_enb), .bram_addrb(b_bram_addrb), .bram_doutb(b_bram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDPR model for A: one-cycle read latency
  always @(posedge clk) begin
    if (bram_ena && bram_wea) mem_a[bram_addra] <= bram_dina;
    if (bram_enb) bram_doutb <= mem_a[bram_addrb];
  end

  // ROM model for B: two-cycle read latency, content = 0x40 + address
  always @(posedge clk) begin
    if (b_bram_enb) b_s1 <= 8'h40 + b_bram_addrb[7:0];
    b_bram_doutb <= b_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1'b1;
    wr_req0 = 0; wr_req1 = 0; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
    rd_req0 = 0; rd_req1 = 0; rd_addr0 = '0; rd_addr1 = '0;
    b_wr_req0 = 0; b_wr_req1 = 0; b_wr_addr0 = '0; b_wr_addr1 = '0; b_wr_data0 = '0; b_wr_data1 = '0;
    b_rd_req0 = 0; b_rd_req1 = 0; b_rd_addr0 = '0; b_rd_addr1 = '0;
    tick();
    tick();

    // Reset: outputs stay idle even with every request raised
    wr_req0 = 1; wr_req1 = 1; rd_req0 = 1; rd_req1 = 1; b_rd_req0 = 1;
    settle();
    chk("rst_wr_gnt0", wr_gnt0, 0);
    chk("rst_wr_gnt1", wr_gnt1, 0);
    chk("rst_rd_gnt0", rd_gnt0, 0);
    chk("rst_rd_gnt1", rd_gnt1, 0);
    chk("rst_b_rd_gnt0", b_rd_gnt0, 0);
    chk("rst_ena", bram_ena, 0);
    chk("rst_wea", bram_wea, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_vld0", rd_vld0, 0);
    chk("rst_vld1", rd_vld1, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_addra", bram_addra, 0);
    chk("rst_addrb", bram_addrb, 0);
    tick();
    wr_req0 = 0; wr_req1 = 0; rd_req0 = 0; rd_req1 = 0; b_rd_req0 = 0;
    rst = 1'b0;
    tick();

    // Contended writes alternate 0,1,0,1; port A follows one cycle later
    wr_addr0 = 11'h010; wr_data0 = 8'h11; wr_addr1 = 11'h020; wr_data1 = 8'h22;
    wr_req0 = 1; wr_req1 = 1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("wr_rr_gnt0", wr_gnt0, (k % 2) == 0);
      chk("wr_rr_gnt1", wr_gnt1, (k % 2) == 1);
      if (k > 0) begin
        chk("wr_rr_ena", bram_ena, 1);
        chk("wr_rr_addra", bram_addra, ((k - 1) % 2 == 0) ? 32'h010 : 32'h020);
      end
      tick();
    end
    wr_req0 = 0; wr_req1 = 0;
    settle();
    chk("wr_last_ena", bram_ena, 1);
    chk("wr_last_wea", bram_wea, 1);
    chk("wr_last_addra", bram_addra, 32'h020);
    chk("wr_last_dina", bram_dina, 32'h22);
    tick();
    settle();
    chk("wr_idle_ena", bram_ena, 0);
    chk("wr_idle_addra_hold", bram_addra, 32'h020);
    tick();

    // Write 0xA5 to 0x100, then aux read of it returns three cycles after grant
    wr_addr0 = 11'h100; wr_data0 = 8'hA5; wr_req0 = 1;
    settle();
    chk("lat_wr_gnt0", wr_gnt0, 1);
    tick();
    wr_req0 = 0; rd_addr1 = 11'h100; rd_req1 = 1;
    settle();
    chk("lat_rd_gnt1", rd_gnt1, 1);
    chk("lat_rd_gnt0", rd_gnt0, 0);
    chk("lat_ena", bram_ena, 1);
    chk("lat_dina", bram_dina, 32'hA5);
    tick();
    rd_req1 = 0;
    settle();
    chk("lat_enb", bram_enb, 1);
    chk("lat_addrb", bram_addrb, 32'h100);
    chk("lat_vld1_g1", rd_vld1, 0);
    tick();
    settle();
    chk("lat_vld1_g2", rd_vld1, 0);
    tick();
    settle();
    chk("lat_vld1_g3", rd_vld1, 1);
    chk("lat_vld0_g3", rd_vld0, 0);
    chk("lat_data_g3", rd_data, 32'hA5);
    tick();
    settle();
    chk("lat_vld1_g4", rd_vld1, 0);
    tick();

    // Both readers held: reader 0 eight times, then a forced aux grant, repeating
    rd_addr0 = 11'h200; rd_addr1 = 11'h201; rd_req0 = 1; rd_req1 = 1;
    for (int k = 0; k < 20; k++) begin
      settle();
      chk("starve_gnt1", rd_gnt1, (k % 9) == 8);
      chk("starve_gnt0", rd_gnt0, (k % 9) != 8);
      tick();
    end
    rd_req0 = 0; rd_req1 = 0;
    repeat (4) tick();

    // Collision: reader 0 hits the write address and yields to reader 1
    wr_addr0 = 11'h055; wr_data0 = 8'h5C; wr_req0 = 1;
    rd_addr0 = 11'h055; rd_req0 = 1; rd_addr1 = 11'h056; rd_req1 = 1;
    settle();
    chk("col_wr_gnt0", wr_gnt0, 1);
    chk("col_rd_gnt0", rd_gnt0, 0);
    chk("col_rd_gnt1", rd_gnt1, 1);
    tick();
    wr_req0 = 0; rd_req1 = 0;
    settle();
    chk("col_rd_gnt0_next", rd_gnt0, 1);
    tick();
    rd_req0 = 0;
    settle();
    chk("col_vld1_early", rd_vld1, 0);
    tick();
    settle();
    chk("col_vld1", rd_vld1, 1);
    chk("col_vld0_early", rd_vld0, 0);
    tick();
    settle();
    chk("col_vld0", rd_vld0, 1);
    chk("col_vld1_after", rd_vld1, 0);
    chk("col_data", rd_data, 32'h5C);
    tick();

    // Reset mid-read: contended write pushes rr to 1, read granted, then reset
    wr_addr0 = 11'h300; wr_data0 = 8'h01; wr_addr1 = 11'h301; wr_data1 = 8'h02;
    wr_req0 = 1; wr_req1 = 1; rd_addr0 = 11'h100; rd_req0 = 1;
    settle();
    chk("mid_wr_gnt0", wr_gnt0, 1);
    chk("mid_wr_gnt1", wr_gnt1, 0);
    chk("mid_rd_gnt0", rd_gnt0, 1);
    tick();
    wr_req0 = 0; wr_req1 = 0; rd_req0 = 0; rst = 1'b1;
    settle();
    chk("mid_enb_before_rst", bram_enb, 1);
    tick();
    rst = 1'b0;
    settle();
    chk("mid_enb", bram_enb, 0);
    chk("mid_ena", bram_ena, 0);
    chk("mid_addra", bram_addra, 0);
    chk("mid_addrb", bram_addrb, 0);
    chk("mid_rd_data", rd_data, 0);
    chk("mid_vld0_0", rd_vld0, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("mid_vld0_drop", rd_vld0, 0);
      chk("mid_vld1_drop", rd_vld1, 0);
      tick();
    end
    wr_req0 = 1; wr_req1 = 1;
    settle();
    chk("rr_after_rst_gnt0", wr_gnt0, 1);
    chk("rr_after_rst_gnt1", wr_gnt1, 0);
    tick();
    wr_req0 = 0; wr_req1 = 0;
    settle();
    chk("rr_after_rst_addra", bram_addra, 32'h300);
    tick();

    // RD_LAT = 2: four back-to-back reads return four cycles after each grant
    for (int k = 0; k < 9; k++) begin
      b_rd_req0 = (k < 4);
      b_rd_addr0 = 11'(k);
      settle();
      if (k < 4) chk("sweep_gnt0", b_rd_gnt0, 1);
      chk("sweep_vld0", b_rd_vld0, (k >= 4) && (k <= 7));
      chk("sweep_vld1", b_rd_vld1, 0);
      if ((k >= 4) && (k <= 7)) chk("sweep_data", b_rd_data, 32'h40 + 32'(k - 4));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
